alu_sequencer: RTL and testbench
================================

# alu_sequencer

Command sequencer for the 16-bit `ALU` datapath. It accepts operation commands over a valid/ready port and buffers them in a small FIFO. It issues each command to the ALU one at a time, returns each result with an error flag over a valid/ready result port, and keeps a 16-bit accumulator so commands can chain on the previous result. It sits between any requester (testbench, future control unit) and the ALU instance, and is the only driver of the ALU's `opcode`, `input1` and `input2`.

## Interface
- `W`, 16: datapath width; must match the ALU width.
- `DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `clk` in 1: single clock, rising-edge.
- `clear` in 1: synchronous active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept.
- `cmd_op` in 4: opcode (shared codes NOOP..RESET).
- `cmd_a` in W: operand A.
- `cmd_b` in W: operand B.
- `cmd_chain` in 1: replace operand A with the accumulator at issue time.
- `alu_opcode` out 4: to ALU `opcode`.
- `alu_in1` out W: to ALU `input1`.
- `alu_in2` out W: to ALU `input2`.
- `alu_out` in W: from ALU `out`; combinational for the current opcode and inputs.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer takes result.
- `res_data` out W: result value.
- `res_err` out 1: divide-by-zero or illegal opcode.
- `busy` out 1: FSM not in IDLE, or FIFO not empty.

## Operation
- **Push:** a command is pushed when `cmd_valid && cmd_ready`. `cmd_ready = (count != DEPTH)`, using the count before any same-cycle pop. A full FIFO therefore never accepts, even in a cycle where it pops.
- **FSM states:** IDLE, EXEC, DONE.
- **IDLE:** if the FIFO is non-empty, pop the head into the issue registers (op, a, b, chain) and go to EXEC. Otherwise stay in IDLE.
- **EXEC (one cycle):** drive the ALU from the issue registers.
  - `alu_in1` = accumulator if chain, else a.
  - `alu_in2` = b.
  - At the clock edge, capture into `res_data`/`res_err` and go to DONE.
- **Capture rules by opcode:**
  - ADD, SUB, MULT, AND, OR, XOR, NOT: `res_data = alu_out`, err = 0. Results are modulo 2^W; MULT keeps the low W bits.
  - DIV with effective b == 0: drive `alu_opcode` = NOOP, `res_data = {W{1}}` (16'hFFFF at default width), err = 1.
  - DIV with b != 0: `res_data = alu_out`, err = 0.
  - NOOP: `res_data` = accumulator, err = 0.
  - RESET: `res_data` = 0, err = 0.
  - Codes 1001–1110: drive NOOP, `res_data` = 0, err = 1.
- **Accumulator:** loaded with `res_data` at the EXEC edge whenever err = 0. RESET loads 0. On err = 1 the accumulator is unchanged.
- **DONE:** `res_valid` = 1. `res_data`/`res_err` are held stable until `res_ready`. On `res_valid && res_ready`, go to IDLE; `res_valid` falls the next cycle.
- **ALU port defaults:** outside EXEC, `alu_opcode` = NOOP and `alu_in1` = `alu_in2` = 0.
- **Clear:** `clear` has priority over every other event.
  - FSM goes to IDLE; FIFO pointers and count go to 0.
  - Accumulator = 0, `res_valid` = 0, `res_data` = 0, `res_err` = 0.
  - The in-flight command and all queued commands are discarded; no result is emitted.
  - A push in the clear cycle is dropped.

## Timing
- **Reset values:** `cmd_ready` = 1, `res_valid` = 0, `res_data` = 0, `res_err` = 0, `alu_opcode` = NOOP (4'b0000), `alu_in*` = 0, `busy` = 0.
- **Latency:** command accepted at edge N (FIFO empty, FSM in IDLE).
  - Popped at edge N+1.
  - EXEC during cycle N+1 → N+2.
  - `res_valid` high from edge N+2.
- **Throughput:** one command per 3 cycles when `res_ready` is held high.
- **Back-pressure:** with `res_ready` low, the FSM stalls in DONE. The FIFO keeps accepting until full; `cmd_ready` then drops.
- **Wrap-around:** FIFO pointers are log2(DEPTH) bits and wrap naturally; `count` is log2(DEPTH)+1 bits.

## Structure
- **Shared package `alu_pkg`:** opcode constants NOOP=0000, ADD=0001, SUB=0010, MULT=0011, DIV=0100, AND=0101, OR=0110, XOR=0111, NOT=1000, RESET=1111. Also the FSM state encoding (IDLE=0, EXEC=1, DONE=2) and the default W. The ALU and its testbench include the same package.
- **Sub-module `cmd_fifo`:** parameterised by width (4+2W+1) and DEPTH. It provides push/pop/full/empty/count and a synchronous `clear`.
- **Sequencer top:** the FSM, issue registers, accumulator and result registers.

## Test plan
- **Chained add:** ADD a=1, b=1, then ADD chain=1, b=5 → results 2 then 7, err = 0; accumulator = 7.
- **MULT wrap:** MULT a=16'h0100, b=16'h0100 → `res_data` 0x0000, err = 0. Then SUB a=3, b=1 → 2.
- **Divide by zero:** DIV a=8, b=0 → `res_data` 16'hFFFF, err = 1, `alu_opcode` stays NOOP during EXEC, accumulator unchanged. Then DIV a=8, b=2 → 4.
- **Back-pressure:** hold `res_ready` = 0 and push 5 commands → 1 in DONE plus 4 in FIFO. `cmd_ready` = 0 after the 5th push, and a 6th is refused. Release `res_ready` → all 5 results arrive in order, one per 3 cycles.
- **Mid-operation clear:** queue 3 commands, assert `clear` during EXEC of the first → no `res_valid` ever rises, `busy` = 0 and `cmd_ready` = 1 the next cycle, accumulator = 0.
- **Illegal opcode and RESET:** op 4'b1010 → data 0, err = 1. RESET → data 0, accumulator 0. A following NOOP → data 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and FSM encodings for the ALU datapath
//
// Purpose: opcode constants shared by the ALU, the sequencer and their benches,
//          the sequencer FSM state encoding, and the default datapath width.
// Ports:   none (package).
package alu_pkg;

    localparam int W_DEFAULT = 16;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_MULT  = 4'b0011;
    localparam logic [3:0] OP_DIV   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1000;
    localparam logic [3:0] OP_RESET = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command FIFO with count and clear
//
// Purpose: DEPTH-entry FIFO; the head entry is visible on pop_data without a pop.
// Ports:
//   clk        in   rising-edge clock
//   clear      in   synchronous active-high clear of pointers and count
//   push       in   write push_data (ignored when full)
//   push_data  in   WIDTH-bit entry
//   pop        in   advance the head (ignored when empty)
//   pop_data   out  current head entry
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  number of stored entries
module cmd_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the pre-pop count, so a full FIFO never accepts.
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - queued command sequencer driving the 16-bit ALU
//
// Purpose: buffers commands, issues them one at a time to the ALU, returns
//          each result with an error flag, and keeps a chaining accumulator.
// Ports:
//   clk, clear                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_a, cmd_b          opcode and operands
//   cmd_chain                     use accumulator as operand A at issue time
//   alu_opcode, alu_in1, alu_in2  drive the ALU (NOOP/0 outside EXEC)
//   alu_out                       combinational ALU result
//   res_valid/res_ready           result handshake
//   res_data, res_err             result value and error flag
//   busy                          FSM not idle or commands queued
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic         cmd_chain,
    output logic [3:0]   alu_opcode,
    output logic [W-1:0] alu_in1,
    output logic [W-1:0] alu_in2,
    input  logic [W-1:0] alu_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_err,
    output logic         busy
);

    localparam int FW = 4 + 2*W + 1;

    seq_state_t              state_q, state_d;
    logic [FW-1:0]           fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    pop;

    logic [3:0]              op_q;
    logic [W-1:0]            a_q;
    logic [W-1:0]            b_q;
    logic                    chain_q;
    logic [W-1:0]            acc_q;
    logic [W-1:0]            res_data_q;
    logic                    res_err_q;

    logic [W-1:0]            eff_a;
    logic [W-1:0]            cap_data;
    logic                    cap_err;

    cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clear     (clear),
        .push      (cmd_valid),
        .push_data ({cmd_op, cmd_a, cmd_b, cmd_chain}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign cmd_ready = !fifo_full;
    assign pop       = (state_q == ST_IDLE) && !fifo_empty;
    assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign eff_a     = chain_q ? acc_q : a_q;

    always_comb begin
        state_d    = state_q;
        alu_opcode = OP_NOOP;
        alu_in1    = '0;
        alu_in2    = '0;
        cap_data   = '0;
        cap_err    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                alu_in1 = eff_a;
                alu_in2 = b_q;
                case (op_q)
                    OP_ADD, OP_SUB, OP_MULT, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                        alu_opcode = op_q;
                        cap_data   = alu_out;
                    end
                    OP_DIV: begin
                        // Never present a zero divisor to the ALU; the
                        // all-ones result is produced here instead.
                        if (b_q == '0) begin
                            cap_data = '1;
                            cap_err  = 1'b1;
                        end else begin
                            alu_opcode = OP_DIV;
                            cap_data   = alu_out;
                        end
                    end
                    OP_NOOP: begin
                        cap_data = acc_q;
                    end
                    OP_RESET: begin
                        alu_opcode = OP_RESET;
                        cap_data   = '0;
                    end
                    default: begin
                        cap_err = 1'b1;
                    end
                endcase
            end
            ST_DONE: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOOP;
            a_q        <= '0;
            b_q        <= '0;
            chain_q    <= 1'b0;
            acc_q      <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                {op_q, a_q, b_q, chain_q} <= fifo_head;
            end
            if (state_q == ST_EXEC) begin
                res_data_q <= cap_data;
                res_err_q  <= cap_err;
                // Errored commands leave the chain value untouched.
                if (!cap_err) acc_q <= cap_data;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with ALU model
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         clear;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_chain;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_in1;
    logic [W-1:0] alu_in2;
    logic [W-1:0] alu_out;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_err;
    logic         busy;

    always #5 clk = ~clk;

    alu_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .clear      (clear),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_chain  (cmd_chain),
        .alu_opcode (alu_opcode),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_out    (alu_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .busy       (busy)
    );

    // Behavioural ALU
    always_comb begin
        case (alu_opcode)
            OP_ADD:  alu_out = alu_in1 + alu_in2;
            OP_SUB:  alu_out = alu_in1 - alu_in2;
            OP_MULT: alu_out = alu_in1 * alu_in2;
            OP_DIV:  alu_out = (alu_in2 != 0) ? alu_in1 / alu_in2 : 16'hDEAD;
            OP_AND:  alu_out = alu_in1 & alu_in2;
            OP_OR:   alu_out = alu_in1 | alu_in2;
            OP_XOR:  alu_out = alu_in1 ^ alu_in2;
            OP_NOT:  alu_out = ~alu_in1;
            default: alu_out = '0;
        endcase
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [16:0] exp_q [$];
    int          hs_cyc [$];
    logic [15:0] acc_m;
    logic [16:0] mon_e;
    bit          rnd_done;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: result of one command from the sequencer's opcode rules.
    function automatic logic [16:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic ch);
        logic [15:0] ea;
        logic [15:0] d;
        logic [31:0] p;
        logic        e;
        ea = ch ? acc_m : a;
        d  = 16'h0;
        e  = 1'b0;
        case (op)
            4'd1: d = ea + b;
            4'd2: d = ea - b;
            4'd3: begin p = ea * b; d = p[15:0]; end
            4'd4: if (b == 0) begin d = 16'hFFFF; e = 1'b1; end else d = ea / b;
            4'd5: d = ea & b;
            4'd6: d = ea | b;
            4'd7: d = ea ^ b;
            4'd8: d = ~ea;
            4'd0: d = acc_m;
            4'd15: d = 16'h0;
            default: e = 1'b1;
        endcase
        if (!e) acc_m = d;
        return {e, d};
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%0h required=none", res_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_data", 32'(res_data), 32'(mon_e[15:0]));
                check("res_err", 32'(res_err), 32'(mon_e[16]));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic ch);
        bit ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_chain = ch;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            exp_q.push_back(model(op, a, b, ch));
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_ready required=ready");
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!busy && !res_valid && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=pending%0d required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        clear     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_chain = 1'b0;
        res_ready = 1'b1;
        acc_m     = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b0;

        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst_alu_in1", 32'(alu_in1), 32'd0);
        check("rst_alu_in2", 32'(alu_in2), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Chained add, then NOOP exposes the accumulator
        send(OP_ADD, 16'd1, 16'd1, 1'b0);
        send(OP_ADD, 16'd0, 16'd5, 1'b1);
        send(OP_NOOP, 16'd0, 16'd0, 1'b0);
        wait_idle();

        // MULT wrap, then SUB
        send(OP_MULT, 16'h0100, 16'h0100, 1'b0);
        send(OP_SUB, 16'd3, 16'd1, 1'b0);
        wait_idle();

        // Divide by zero with EXEC-cycle port checks and latency
        send(OP_DIV, 16'd8, 16'd0, 1'b0);
        @(negedge clk);
        check("lat_idle_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("div0_opcode", 32'(alu_opcode), 32'(OP_NOOP));
        check("exec_in1", 32'(alu_in1), 32'd8);
        check("lat_exec_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("lat_done_valid", 32'(res_valid), 32'd1);
        @(posedge clk);
        #1;
        send(OP_ADD, 16'd0, 16'd0, 1'b1);
        send(OP_DIV, 16'd8, 16'd2, 1'b0);
        wait_idle();

        // Illegal opcode and RESET
        send(OP_ADD, 16'd5, 16'd6, 1'b0);
        send(4'b1010, 16'd1, 16'd2, 1'b0);
        send(OP_NOOP, 16'd0, 16'd0, 1'b0);
        send(OP_RESET, 16'd7, 16'd7, 1'b0);
        send(OP_NOOP, 16'd0, 16'd0, 1'b0);
        wait_idle();

        // Back-pressure: one in DONE plus a full FIFO
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(OP_ADD, 16'($urandom_range(1, 100)), 16'($urandom_range(1, 100)), 1'b0);
        @(negedge clk);
        check("bp_full_ready", 32'(cmd_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_a     = 16'd1;
        cmd_b     = 16'd1;
        cmd_chain = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cmd_ready) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("bp_sixth_refused", 32'(seen), 32'd0);
        hs_cyc.delete();
        res_ready = 1'b1;
        wait_idle();
        check("bp_result_count", 32'(hs_cyc.size()), 32'd5);
        for (int i = 1; i < hs_cyc.size(); i++)
            check("bp_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);

        // Mid-operation clear
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_a     = 16'd1;
        cmd_b     = 16'd2;
        cmd_chain = 1'b0;
        @(posedge clk);
        #1;
        cmd_op = OP_SUB;
        cmd_a  = 16'd5;
        cmd_b  = 16'd3;
        @(posedge clk);
        #1;
        cmd_op = OP_XOR;
        clear  = 1'b1;
        @(negedge clk);
        check("clr_exec_opcode", 32'(alu_opcode), 32'(OP_ADD));
        @(posedge clk);
        #1;
        clear     = 1'b0;
        cmd_valid = 1'b0;
        acc_m     = 16'h0;
        @(negedge clk);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_cmd_ready", 32'(cmd_ready), 32'd1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("clr_no_result", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        send(OP_NOOP, 16'd0, 16'd0, 1'b0);
        send(OP_ADD, 16'd0, 16'd9, 1'b1);
        wait_idle();

        // Randomized traffic with random result back-pressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++)
                    send(4'($urandom_range(0, 15)), 16'($urandom),
                         ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                         1'($urandom_range(0, 1)));
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    res_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        res_ready = 1'b1;
        wait_idle();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
